sram_access_sequencer: RTL and testbench
========================================

SRAM_ACCESS_SEQUENCER -- requirements
Module: sram_access_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: read-wait cycles before timeout, range 1..65535.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port cmd_read, input, 1: debounced level read request, already active-high.
REQ-005 SHALL have port cmd_write, input, 1: debounced level write request, already active-high.
REQ-006 SHALL have port cmd_addr, input, 19: word address for the next command.
REQ-007 SHALL have port cmd_wdata, input, 16: write data for the next command.
REQ-008 SHALL have port av_address, output, 19: Avalon-MM master address to the SRAM slave.
REQ-009 SHALL have port av_byteenable, output, 2: constant 2'b11.
REQ-010 SHALL have ports av_read and av_write, output, 1 each: Avalon-MM transfer strobes.
REQ-011 SHALL have port av_writedata, output, 16: Avalon-MM write data.
REQ-012 SHALL have ports av_readdata, input, 16, and av_readdatavalid, input, 1: slave read response.
REQ-013 SHALL have port av_waitrequest, input, 1: slave stall. Tie 0 for slaves without it.
REQ-014 SHALL have port rd_data, output, 16: last captured read data.
REQ-015 SHALL have port rd_valid, output, 1: rd_data holds the result of the last read.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-017 SHALL have port err, output, 1: last read timed out.

Function
REQ-018 SHALL detect commands only on rising edges: input sampled 1 while its previous-cycle sample is 0.
REQ-019 SHALL accept a command only in IDLE. Edges arriving in any other state SHALL be discarded, not queued.
REQ-020 SHALL, on acceptance, latch cmd_addr and cmd_wdata. It SHALL clear rd_valid and err.
REQ-021 SHALL perform the write when read and write edges occur in the same cycle. The read edge is dropped.
REQ-022 SHALL implement the FSM IDLE, RD_REQ, RD_WAIT, WR_REQ. Outputs SHALL be registered. The strobe asserts in the first cycle after the accepting edge.
REQ-023 In IDLE->WR_REQ, av_write=1 with latched address and data. The strobe SHALL hold until a cycle with av_waitrequest=0, then return to IDLE.
REQ-024 In IDLE->RD_REQ, av_read=1. The strobe SHALL hold until av_waitrequest=0, then go to RD_WAIT.
REQ-025 If av_readdatavalid=1 in the RD_REQ cycle where waitrequest=0, the block SHALL capture data, set rd_valid, and go directly to IDLE.
REQ-026 In RD_WAIT, av_readdatavalid=1 SHALL load rd_data from av_readdata, set rd_valid=1, and return to IDLE.
REQ-027 SHALL ignore av_readdatavalid in IDLE and WR_REQ. rd_data SHALL be unchanged.
REQ-028 rd_valid SHALL stay high until the next accepted command or reset.
REQ-029 av_read and av_write SHALL never be high together. Both SHALL be 0 in IDLE and RD_WAIT.
REQ-030 av_address and av_writedata SHALL hold the latched values outside transfers.

Reset
REQ-031 While reset=1, state SHALL be IDLE, with av_read, av_write, rd_valid, busy and err all 0.
REQ-032 While reset=1, av_address, av_writedata, rd_data and the timeout counter SHALL be 0.
REQ-033 Edge-detect registers SHALL reset to 1, so inputs held through reset release issue no command.
REQ-034 Reset mid-transfer SHALL drop strobes immediately. Any later av_readdatavalid SHALL be ignored.

Configuration
REQ-035 With macro SRAM_SEQ_TIMEOUT_EN defined, the block SHALL include a 16-bit counter that clears on entry to RD_WAIT and increments each cycle there.
REQ-036 With SRAM_SEQ_TIMEOUT_EN defined, the block SHALL set err=1 and return to IDLE with rd_valid=0 when the count reaches TIMEOUT_CYCLES without av_readdatavalid.
REQ-037 Without SRAM_SEQ_TIMEOUT_EN, RD_WAIT SHALL wait indefinitely, err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-038 Write: cmd_addr=0x00012 and cmd_wdata=0xA5C3, waitrequest 0, then rise cmd_write. Expect exactly one av_write cycle with those values, busy high for 1 cycle.
REQ-039 Read: same address, rise cmd_read, waitrequest high for 2 cycles, readdatavalid 2 cycles later with 0xA5C3. Expect av_read high 3 cycles, rd_data=0xA5C3, rd_valid=1 sticky.
REQ-040 Simultaneous: cmd_read and cmd_write rise in the same cycle. Expect a write only. Then hold cmd_read high for 50 cycles: expect no further transfer.
REQ-041 Timeout (macro on, TIMEOUT_CYCLES=8): issue a read and never return readdatavalid. Expect err=1 and IDLE after 8 RD_WAIT cycles. The next command clears err.
REQ-042 Reset: assert reset while in RD_WAIT, with cmd_read held high across release, then pulse readdatavalid. Expect IDLE, no new av_read, rd_valid=0.

Source files
------------

// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer: edge-triggered read/write commands to an Avalon-MM SRAM slave.
// Optional read timeout enabled by `define SRAM_SEQ_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module sram_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_read,
  input  logic        cmd_write,
  input  logic [18:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic [18:0] av_address,
  output logic [1:0]  av_byteenable,
  output logic        av_read,
  output logic        av_write,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        av_readdatavalid,
  input  logic        av_waitrequest,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR_REQ  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_rd_prev;
  logic        r_wr_prev;
  logic        r_av_read;
  logic        r_av_write;
  logic [18:0] r_av_address;
  logic [15:0] r_av_writedata;
  logic [15:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_busy;
  logic        w_rd_edge;
  logic        w_wr_edge;

  assign w_rd_edge = cmd_read & ~r_rd_prev;
  assign w_wr_edge = cmd_write & ~r_wr_prev;

`ifdef SRAM_SEQ_TIMEOUT_EN
  localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;
  logic        r_err;
  logic        w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == C_TMO_LAST);
  assign err       = r_err;
`else
  assign err = 1'b0;
`endif

  // Edge-detect flops reset high so a command held through reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rd_prev      <= 1'b1;
      r_wr_prev      <= 1'b1;
      r_av_read      <= 1'b0;
      r_av_write     <= 1'b0;
      r_av_address   <= '0;
      r_av_writedata <= '0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_busy         <= 1'b0;
`ifdef SRAM_SEQ_TIMEOUT_EN
      r_tmo_cnt      <= '0;
      r_err          <= 1'b0;
`endif
    end else begin
      r_rd_prev <= cmd_read;
      r_wr_prev <= cmd_write;
      case (r_state)
        S_IDLE: begin
          if (w_wr_edge || w_rd_edge) begin
            r_av_address   <= cmd_addr;
            r_av_writedata <= cmd_wdata;
            r_rd_valid     <= 1'b0;
            r_busy         <= 1'b1;
`ifdef SRAM_SEQ_TIMEOUT_EN
            r_err          <= 1'b0;
`endif
            // A write edge wins; a coincident read edge is simply dropped.
            if (w_wr_edge) begin
              r_state    <= S_WR_REQ;
              r_av_write <= 1'b1;
            end else begin
              r_state   <= S_RD_REQ;
              r_av_read <= 1'b1;
            end
          end
        end
        S_WR_REQ: begin
          if (!av_waitrequest) begin
            r_state    <= S_IDLE;
            r_av_write <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        S_RD_REQ: begin
          if (!av_waitrequest) begin
            r_av_read <= 1'b0;
            if (av_readdatavalid) begin
              r_rd_data  <= av_readdata;
              r_rd_valid <= 1'b1;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_state <= S_RD_WAIT;
`ifdef SRAM_SEQ_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end
          end
        end
        S_RD_WAIT: begin
          if (av_readdatavalid) begin
            r_rd_data  <= av_readdata;
            r_rd_valid <= 1'b1;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
          end
`ifdef SRAM_SEQ_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        default: begin
          r_state    <= S_IDLE;
          r_av_read  <= 1'b0;
          r_av_write <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign av_address    = r_av_address;
  assign av_byteenable = 2'b11;
  assign av_read       = r_av_read;
  assign av_write      = r_av_write;
  assign av_writedata  = r_av_writedata;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sram_access_sequencer.sv
// tb_sram_access_sequencer: directed scenarios plus randomized transactions against
// a transaction-level memory model and a randomized Avalon slave.  Rev 1.0
`default_nettype none

module tb_sram_access_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_read = 1'b0;
  logic        cmd_write = 1'b0;
  logic [18:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [18:0] av_address;
  logic [1:0]  av_byteenable;
  logic        av_read;
  logic        av_write;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_readdatavalid;
  logic        av_waitrequest;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        err;

  logic        slave_auto = 1'b0;
  logic        dir_wait = 1'b0;
  logic        dir_rdv = 1'b0;
  logic [15:0] dir_rdata = '0;
  logic        auto_wait = 1'b0;
  logic        auto_rdv = 1'b0;
  logic [15:0] auto_rdata = '0;

  assign av_waitrequest   = slave_auto ? auto_wait  : dir_wait;
  assign av_readdatavalid = slave_auto ? auto_rdv   : dir_rdv;
  assign av_readdata      = slave_auto ? auto_rdata : dir_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int acc_rd = 0;
  int acc_wr = 0;
  int pend = 0;
  logic [15:0] pend_data = '0;
  logic [15:0] slave_mem [logic [18:0]];
  logic [15:0] ref_mem   [logic [18:0]];

  sram_access_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_read(cmd_read), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .av_address(av_address), .av_byteenable(av_byteenable),
    .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .av_waitrequest(av_waitrequest),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [18:0] a);
    return a[15:0] ^ 16'h5A5A ^ {13'd0, a[18:16]};
  endfunction

  // Protocol invariants, every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      check_val("strobe_excl", 32'(av_read & av_write), 32'd0);
      check_val("byteenable", 32'(av_byteenable), 32'd3);
      if (!busy) check_val("idle_strobe", 32'(av_read | av_write), 32'd0);
    end
  end

  // Randomized slave: random stalls, 0..3 cycle read latency, stray readdatavalid when harmless.
  always @(negedge clk) begin
    if (slave_auto) begin
      logic [15:0] v;
      auto_rdv  = 1'b0;
      auto_wait = ($urandom_range(0, 2) == 0);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          auto_rdv   = 1'b1;
          auto_rdata = pend_data;
        end
      end
      if (av_write && !auto_wait) begin
        slave_mem[av_address] = av_writedata;
        acc_wr++;
      end
      if (av_read && !auto_wait) begin
        acc_rd++;
        v = slave_mem.exists(av_address) ? slave_mem[av_address] : dflt(av_address);
        if ($urandom_range(0, 2) == 0) begin
          auto_rdv   = 1'b1;
          auto_rdata = v;
        end else begin
          pend      = $urandom_range(1, 3);
          pend_data = v;
        end
      end else if (!auto_rdv && pend == 0 && (!busy || av_write) && $urandom_range(0, 7) == 0) begin
        auto_rdv   = 1'b1;
        auto_rdata = 16'($urandom);
      end
    end else begin
      pend     = 0;
      auto_rdv = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int nw, nr, nb, guard, r0, w0, kind;
    logic [18:0] cap_addr, a;
    logic [15:0] cap_data, d, exp_rd;
    logic is_wr;
    logic [18:0] pool [8];

    // Reset: commands held high across release must not start anything.
    cmd_read = 1'b1; cmd_write = 1'b1;
    tick(); tick();
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_av_read", 32'(av_read), 0);
    check_val("rst_av_write", 32'(av_write), 0);
    check_val("rst_rd_valid", 32'(rd_valid), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_av_address", 32'(av_address), 0);
    check_val("rst_av_writedata", 32'(av_writedata), 0);
    check_val("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    nb = 0;
    repeat (5) begin tick(); if (busy) nb++; end
    check_val("rst_held_no_cmd", 32'(nb), 0);

    // Single write.
    cmd_read = 1'b0; cmd_write = 1'b0; dir_wait = 1'b0;
    tick();
    cmd_addr = 19'h00012; cmd_wdata = 16'hA5C3; cmd_write = 1'b1;
    nw = 0; nb = 0; cap_addr = '0; cap_data = '0;
    repeat (6) begin
      tick();
      if (av_write) begin nw++; cap_addr = av_address; cap_data = av_writedata; end
      if (busy) nb++;
    end
    check_val("wr_cycles", 32'(nw), 1);
    check_val("wr_busy_cycles", 32'(nb), 1);
    check_val("wr_addr", 32'(cap_addr), 32'h12);
    check_val("wr_data", 32'(cap_data), 32'hA5C3);
    check_val("wr_addr_hold", 32'(av_address), 32'h12);
    cmd_write = 1'b0;

    // Read with two stall cycles and data two cycles after the handshake.
    tick();
    cmd_read = 1'b1; dir_wait = 1'b1;
    nr = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (av_read) nr++;
      dir_wait  = (i < 3);
      dir_rdv   = (i == 5);
      dir_rdata = (i == 5) ? 16'hA5C3 : 16'h0000;
    end
    check_val("rd_cycles", 32'(nr), 3);
    check_val("rd_data", 32'(rd_data), 32'hA5C3);
    check_val("rd_valid", 32'(rd_valid), 1);
    check_val("rd_busy_done", 32'(busy), 0);
    repeat (5) tick();
    check_val("rd_valid_sticky", 32'(rd_valid), 1);

    // Simultaneous edges: write only, then a held read level issues nothing.
    cmd_read = 1'b0; cmd_write = 1'b0;
    tick();
    cmd_addr = 19'h00034; cmd_wdata = 16'h1111; cmd_read = 1'b1; cmd_write = 1'b1;
    nw = 0; nr = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (av_write) nw++;
      if (av_read) nr++;
      if (i == 3) cmd_write = 1'b0;
    end
    check_val("both_wr_cycles", 32'(nw), 1);
    check_val("both_rd_cycles", 32'(nr), 0);
    check_val("both_rd_valid_clr", 32'(rd_valid), 0);
    check_val("both_rd_data_kept", 32'(rd_data), 32'hA5C3);
    cmd_read = 1'b0;
    tick();

    // Read that never gets a response.
    cmd_addr = 19'h00055; cmd_read = 1'b1; dir_wait = 1'b0; dir_rdv = 1'b0;
    nb = 0;
`ifdef SRAM_SEQ_TIMEOUT_EN
    for (int i = 1; i <= 20; i++) begin tick(); if (busy) nb++; end
    check_val("tmo_busy_cycles", 32'(nb), 9);
    check_val("tmo_err", 32'(err), 1);
    check_val("tmo_rd_valid", 32'(rd_valid), 0);
    cmd_read = 1'b0;
    tick();
    cmd_write = 1'b1;
    repeat (4) tick();
    check_val("tmo_err_cleared", 32'(err), 0);
    cmd_write = 1'b0;
`else
    for (int i = 1; i <= 30; i++) begin tick(); if (busy) nb++; end
    check_val("wait_busy_cycles", 32'(nb), 30);
    check_val("wait_err", 32'(err), 0);
    dir_rdv = 1'b1; dir_rdata = 16'h0BEE;
    tick();
    dir_rdv = 1'b0;
    tick();
    check_val("wait_rd_data", 32'(rd_data), 32'h0BEE);
    check_val("wait_rd_valid", 32'(rd_valid), 1);
    check_val("wait_busy_done", 32'(busy), 0);
    cmd_read = 1'b0;
`endif
    tick();

    // Reset while waiting for read data, read level held across release.
    cmd_addr = 19'h00077; cmd_read = 1'b1; dir_wait = 1'b0;
    tick(); tick();
    check_val("rr_in_wait", 32'({busy, av_read}), 32'h2);
    reset = 1'b1;
    #1;
    check_val("rr_async_busy", 32'(busy), 0);
    check_val("rr_async_av_read", 32'(av_read), 0);
    tick();
    reset = 1'b0;
    tick();
    dir_rdv = 1'b1; dir_rdata = 16'hFFFF;
    tick();
    dir_rdv = 1'b0;
    nr = 0; nb = 0;
    repeat (10) begin tick(); if (av_read) nr++; if (busy) nb++; end
    check_val("rr_no_read", 32'(nr), 0);
    check_val("rr_no_busy", 32'(nb), 0);
    check_val("rr_rd_valid", 32'(rd_valid), 0);
    check_val("rr_rd_data", 32'(rd_data), 0);
    cmd_read = 1'b0;

    // Randomized transactions against the memory model.
    exp_rd = 16'h0000;
    foreach (pool[i]) pool[i] = 19'($urandom);
    slave_auto = 1'b1;
    for (int t = 0; t < 150; t++) begin
      tick();
      cmd_read = 1'b0; cmd_write = 1'b0;
      tick();
      kind  = $urandom_range(0, 9);
      a     = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 19'($urandom);
      d     = 16'($urandom);
      is_wr = (kind < 4) || (kind >= 8);
      cmd_addr = a; cmd_wdata = d;
      cmd_read = (kind >= 4); cmd_write = is_wr;
      r0 = acc_rd; w0 = acc_wr;
      tick();
      check_val("rnd_busy_start", 32'(busy), 1);
      guard = 0;
      while (busy && guard < 200) begin
        if ($urandom_range(0, 3) == 0) cmd_read = ~cmd_read;
        if ($urandom_range(0, 3) == 0) cmd_write = ~cmd_write;
        tick();
        guard++;
      end
      check_val("rnd_hang", 32'(guard >= 200), 0);
      if (is_wr) begin
        ref_mem[a] = d;
        check_val("rnd_wr_count", 32'(acc_wr - w0), 1);
        check_val("rnd_wr_rdcount", 32'(acc_rd - r0), 0);
        check_val("rnd_wr_mem", 32'(slave_mem.exists(a) ? slave_mem[a] : ~d), 32'(d));
        check_val("rnd_wr_rd_valid", 32'(rd_valid), 0);
      end else begin
        exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        check_val("rnd_rd_count", 32'(acc_rd - r0), 1);
        check_val("rnd_rd_wrcount", 32'(acc_wr - w0), 0);
        check_val("rnd_rd_valid", 32'(rd_valid), 1);
      end
      check_val("rnd_rd_data", 32'(rd_data), 32'(exp_rd));
      check_val("rnd_err", 32'(err), 0);
    end
    slave_auto = 1'b0;
    cmd_read = 1'b0; cmd_write = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
